fetch_ctrl: RTL and testbench

FETCH_CTRL -- requirements
Module: fetch_ctrl

---
 rtl/fetch_ctrl.sv | 145 ++++++++++++++
 tb/tb_fetch_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: program-counter sequencing for the fetch stage.
//
// Tracks the fetch-stage PC and runs a BOOT -> RUN <-> HALT state machine. Redirects that
// arrive while fetch cannot advance are parked in a pending register and take effect at the
// next advance. An advance is a cycle with fetch_enable=1 and combined_stall=0.
//
// Optional feature macro: FETCH_CTRL_MISALIGN_TRAP_EN
//   defined   : a misaligned redirect target is replaced by TRAP_VEC, and misalign_trap pulses
//               in the advance cycle that uses it.
//   undefined : misaligned redirect targets have bits [1:0] forced to zero. misalign_trap is
//               not present.
//
// Ports:
//   clk            in   clock, rising edge
//   reset_n        in   asynchronous active-low reset
//   combined_stall in   global pipeline stall
//   branch_taken   in   one-cycle redirect request
//   branch_target  in   redirect address, qualified by branch_taken
//   halt_req       in   request to stop fetching
//   resume_req     in   request to leave HALT
//   fetch_enable   out  fetch enable, high only in RUN
//   next_pc        out  next fetch address (combinational)
//   flush_if_id    out  invalidate IF/ID, high when an advance uses a redirect address
//   halted         out  high while in HALT
//   misalign_trap  out  misaligned-redirect pulse (trap build only)
//   instr_count    out  number of advances, wraps at 2^32

module fetch_ctrl #(
   parameter logic [31:0] BOOT_ADDR = 32'h0000_0000,
   parameter logic [31:0] TRAP_VEC  = 32'h0000_0100
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        combined_stall,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   input  logic        halt_req,
   input  logic        resume_req,
   output logic        fetch_enable,
   output logic [31:0] next_pc,
   output logic        flush_if_id,
   output logic        halted,
`ifdef FETCH_CTRL_MISALIGN_TRAP_EN
   output logic        misalign_trap,
`endif
   output logic [31:0] instr_count
);

   typedef enum logic [1:0] {StBoot, StRun, StHalt} state_e;

   state_e      state_q, state_d;
   logic [31:0] fetch_pc_q, fetch_pc_d;
   logic        pend_valid_q, pend_valid_d;
   logic [31:0] pend_addr_q, pend_addr_d;
   logic [31:0] count_q, count_d;

   logic        run;
   logic        advance;
   logic        redirect;
   logic [31:0] redirect_addr;
   logic [31:0] redirect_pc;

   // Datapath and outputs
   always_comb begin
      run           = (state_q == StRun);
      advance       = run & ~combined_stall;
      // A live branch only steers next_pc in RUN; outside RUN it is parked instead. This also
      // keeps next_pc at BOOT_ADDR+4 while reset holds the FSM in BOOT.
      redirect      = pend_valid_q | (run & branch_taken);
      redirect_addr = pend_valid_q ? pend_addr_q : branch_target;
`ifdef FETCH_CTRL_MISALIGN_TRAP_EN
      redirect_pc   = (redirect_addr[1:0] != 2'b00) ? TRAP_VEC : redirect_addr;
`else
      redirect_pc   = redirect_addr & ~32'h3;
`endif
      next_pc       = redirect ? redirect_pc : fetch_pc_q + 32'd4;
      fetch_enable  = run;
      flush_if_id   = advance & redirect;
      halted        = (state_q == StHalt);
      instr_count   = count_q;
   end

`ifdef FETCH_CTRL_MISALIGN_TRAP_EN
   assign misalign_trap = advance & redirect & (redirect_addr[1:0] != 2'b00);
`else
   // TRAP_VEC has no role without the trap feature.
   logic unused_trap_vec;
   assign unused_trap_vec = ^TRAP_VEC;
`endif

   // PC, counter and pending-redirect next state
   always_comb begin
      fetch_pc_d   = fetch_pc_q;
      count_d      = count_q;
      pend_valid_d = pend_valid_q;
      pend_addr_d  = pend_addr_q;

      if (advance) begin
         fetch_pc_d   = next_pc;
         count_d      = count_q + 32'd1;
         // Any pending redirect was consumed by this advance.
         pend_valid_d = 1'b0;
      end else if (branch_taken) begin
         // Newest request wins over an unapplied one.
         pend_valid_d = 1'b1;
         pend_addr_d  = branch_target;
      end
   end

   // FSM next state
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StBoot: state_d = StRun;
         StRun: begin
            if (halt_req && !combined_stall) begin
               state_d = StHalt;
            end
         end
         StHalt: begin
            if (!halt_req && resume_req) begin
               state_d = StRun;
            end
         end
         default: state_d = StBoot;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= StBoot;
         fetch_pc_q   <= BOOT_ADDR;
         pend_valid_q <= 1'b0;
         pend_addr_q  <= 32'h0;
         count_q      <= 32'h0;
      end else begin
         state_q      <= state_d;
         fetch_pc_q   <= fetch_pc_d;
         pend_valid_q <= pend_valid_d;
         pend_addr_q  <= pend_addr_d;
         count_q      <= count_d;
      end
   end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Testbench for fetch_ctrl. Directed stimulus pushes the expected contents of each advance
// cycle (next_pc, flush_if_id, instr_count before the increment, misalign_trap) into a queue;
// a monitor pops and compares on every advance. Level checks (reset values, halted, stall
// behaviour) are made inline by the stimulus process.

module tb_fetch_ctrl;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        combined_stall;
   logic        branch_taken;
   logic [31:0] branch_target;
   logic        halt_req;
   logic        resume_req;
   logic        fetch_enable;
   logic [31:0] next_pc;
   logic        flush_if_id;
   logic        halted;
   logic [31:0] instr_count;
`ifdef FETCH_CTRL_MISALIGN_TRAP_EN
   logic        misalign_trap;
`endif

   typedef struct {
      logic [31:0] pc;
      logic        flush;
      logic [31:0] cnt;
      logic        trap;
   } exp_t;

   exp_t exp_q[$];
   int   tests = 0;
   int   errors = 0;

   fetch_ctrl #(
      .BOOT_ADDR(32'h0000_0000),
      .TRAP_VEC (32'h0000_0100)
   ) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .combined_stall(combined_stall),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .halt_req      (halt_req),
      .resume_req    (resume_req),
      .fetch_enable  (fetch_enable),
      .next_pc       (next_pc),
      .flush_if_id   (flush_if_id),
      .halted        (halted),
`ifdef FETCH_CTRL_MISALIGN_TRAP_EN
      .misalign_trap (misalign_trap),
`endif
      .instr_count   (instr_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic push(input logic [31:0] pc, input logic flush, input logic [31:0] cnt,
                       input logic trap);
      exp_t e;
      e.pc = pc;
      e.flush = flush;
      e.cnt = cnt;
      e.trap = trap;
      exp_q.push_back(e);
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_fetch_enable"}, {31'b0, fetch_enable}, 32'h0);
      chk({tag, "_flush"}, {31'b0, flush_if_id}, 32'h0);
      chk({tag, "_halted"}, {31'b0, halted}, 32'h0);
      chk({tag, "_next_pc"}, next_pc, 32'h4);
      chk({tag, "_instr_count"}, instr_count, 32'h0);
   endtask

   // Monitor: every advance must match the head of the expectation queue.
   always @(negedge clk) begin
      if (reset_n && fetch_enable && !combined_stall) begin
         if (exp_q.size() == 0) begin
            tests++;
            errors++;
            $display("FAIL unexpected_advance: next_pc %h, expected no advance", next_pc);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("adv_next_pc", next_pc, e.pc);
            chk("adv_flush", {31'b0, flush_if_id}, {31'b0, e.flush});
            chk("adv_instr_count", instr_count, e.cnt);
`ifdef FETCH_CTRL_MISALIGN_TRAP_EN
            chk("adv_misalign_trap", {31'b0, misalign_trap}, {31'b0, e.trap});
`endif
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n        = 1'b0;
      combined_stall = 1'b0;
      branch_taken   = 1'b1;
      branch_target  = 32'h300;
      halt_req       = 1'b0;
      resume_req     = 1'b0;

      // Reset values hold even with a branch request on the input.
      @(negedge clk);
      chk_reset_vals("rst");
      branch_taken = 1'b0;

      // Boot: one idle cycle, then sequential fetch.
      push(32'h4, 1'b0, 32'd0, 1'b0);
      push(32'h8, 1'b0, 32'd1, 1'b0);
      push(32'hC, 1'b0, 32'd2, 1'b0);
      cyc();
      reset_n = 1'b1;
      @(negedge clk);
      chk("boot_fetch_enable", {31'b0, fetch_enable}, 32'h0);
      repeat (4) cyc();

      // Branch under a 3-cycle stall: parked, then applied with a single flush.
      combined_stall = 1'b1;
      branch_taken   = 1'b1;
      branch_target  = 32'h200;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("stall_flush", {31'b0, flush_if_id}, 32'h0);
         chk("stall_next_pc", next_pc, 32'h200);
         cyc();
         branch_taken = 1'b0;
      end
      combined_stall = 1'b0;
      push(32'h200, 1'b1, 32'd3, 1'b0);
      push(32'h204, 1'b0, 32'd4, 1'b0);
      cyc();
      cyc();

      // Halt together with a branch: the redirect advance completes, then HALT.
      halt_req      = 1'b1;
      branch_taken  = 1'b1;
      branch_target = 32'h40;
      push(32'h40, 1'b1, 32'd5, 1'b0);
      cyc();
      halt_req     = 1'b0;
      branch_taken = 1'b0;
      @(negedge clk);
      chk("halt_halted", {31'b0, halted}, 32'h1);
      chk("halt_fetch_enable", {31'b0, fetch_enable}, 32'h0);
      chk("halt_next_pc", next_pc, 32'h44);
      cyc();
      resume_req = 1'b1;
      push(32'h44, 1'b0, 32'd6, 1'b0);
      cyc();
      // Back in RUN; halt again right after this advance.
      resume_req = 1'b0;
      halt_req   = 1'b1;
      cyc();

      // halt_req and resume_req together keep HALT; dropping halt_req resumes.
      resume_req = 1'b1;
      @(negedge clk);
      chk("both_req_halted", {31'b0, halted}, 32'h1);
      cyc();
      halt_req = 1'b0;
      push(32'h48, 1'b0, 32'd7, 1'b0);
      @(negedge clk);
      chk("resume_pending_halted", {31'b0, halted}, 32'h1);
      cyc();
      resume_req = 1'b0;
      @(negedge clk);
      chk("resumed_halted", {31'b0, halted}, 32'h0);
      cyc();

      // Misaligned redirect target.
      branch_taken  = 1'b1;
      branch_target = 32'h202;
`ifdef FETCH_CTRL_MISALIGN_TRAP_EN
      push(32'h100, 1'b1, 32'd8, 1'b1);
`else
      push(32'h200, 1'b1, 32'd8, 1'b0);
`endif
      cyc();

      // PC wrap at the top of the address space, then halt.
      branch_target = 32'hFFFF_FFFC;
      push(32'hFFFF_FFFC, 1'b1, 32'd9, 1'b0);
      cyc();
      branch_taken = 1'b0;
      halt_req     = 1'b1;
      push(32'h0, 1'b0, 32'd10, 1'b0);
      cyc();

      // Park a redirect while halted, then reset mid-operation.
      halt_req      = 1'b0;
      branch_taken  = 1'b1;
      branch_target = 32'h500;
      cyc();
      branch_taken = 1'b0;
      @(negedge clk);
      chk("pend_halted", {31'b0, halted}, 32'h1);
      chk("pend_next_pc", next_pc, 32'h500);
      chk("pend_flush", {31'b0, flush_if_id}, 32'h0);
      #3;
      reset_n = 1'b0;
      #1;
      chk_reset_vals("async_rst");

      // Restart from BOOT_ADDR; the parked redirect must be gone.
      push(32'h4, 1'b0, 32'd0, 1'b0);
      push(32'h8, 1'b0, 32'd1, 1'b0);
      cyc();
      reset_n = 1'b1;
      @(negedge clk);
      chk("reboot_fetch_enable", {31'b0, fetch_enable}, 32'h0);
      cyc();
      cyc();
      cyc();
      combined_stall = 1'b1;
      @(negedge clk);
      chk("final_flush", {31'b0, flush_if_id}, 32'h0);
      repeat (2) cyc();

      chk("leftover_expectations", exp_q.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, errors);
      $finish;
   end

endmodule
